rv32_regfile_sb: RTL

- Parametrised multi-port integer register file for the RV32I core; successor to the 2R1W file.
- Configurable read/write port counts, per-register pending (scoreboard) bits for issue/writeback tracking, and a post-reset clear sequencer that zeroes the array one entry per cycle.
- Sits between decode/issue (reads, busy checks, rd reservation) and writeback (one port per retiring lane).

---
 rtl/rv32_regfile_sb.sv | 104 ++++++++++
 1 files changed

// File: rtl/rv32_regfile_sb.sv
// Multi-port RV32I integer register file with per-register pending bits and a post-reset clear sequencer.
// Define RF_BYPASS_EN for same-cycle write-to-read bypass; otherwise writes become readable the cycle after.
module rv32_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NR     = 32,
  parameter int ADDR_W = 5,
  parameter int NRP    = 3,
  parameter int NWP    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   ready_o,
  input  logic [NWP-1:0]         we_i,
  input  logic [NWP*ADDR_W-1:0]  waddr_i,
  input  logic [NWP*XLEN-1:0]    wdata_i,
  input  logic [NRP*ADDR_W-1:0]  raddr_i,
  output logic [NRP*XLEN-1:0]    rdata_o,
  output logic [NRP-1:0]         busy_o,
  input  logic                   iss_v_i,
  input  logic [ADDR_W-1:0]      iss_rd_i,
  output logic [NR-1:0]          pend_o
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_idx, clr_idx_nxt;
  logic [NR-1:0]       pending, pending_nxt;
  logic [XLEN-1:0]     regs [NR];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_CLEAR;
      clr_idx <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    pending_nxt = pending;
    case (state)
      S_CLEAR: begin
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == ADDR_W'(NR-1)) state_nxt = S_READY;
      end
      S_READY: begin
        for (int k = 0; k < NWP; k++) begin
          if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] != '0))
            pending_nxt[waddr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
        // A new reservation supersedes a retiring producer of the same register.
        if (iss_v_i && (iss_rd_i != '0)) pending_nxt[iss_rd_i] = 1'b1;
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  // Array is not reset directly; the clear sequencer zeroes it one entry per cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == S_CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int k = 0; k < NWP; k++) begin
          if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] != '0))
            regs[waddr_i[k*ADDR_W +: ADDR_W]] <= wdata_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  assign ready_o = (state == S_READY);
  assign pend_o  = {pending[NR-1:1], 1'b0};

  always_comb begin
    rdata_o = '0;
    busy_o  = '0;
    for (int p = 0; p < NRP; p++) begin
      logic [ADDR_W-1:0] ra;
      logic              hit;
      ra  = raddr_i[p*ADDR_W +: ADDR_W];
      hit = 1'b0;
      if (ready_o && (ra != '0)) begin
        rdata_o[p*XLEN +: XLEN] = regs[ra];
`ifdef RF_BYPASS_EN
        for (int k = 0; k < NWP; k++) begin
          if (we_i[k] && (waddr_i[k*ADDR_W +: ADDR_W] == ra)) begin
            rdata_o[p*XLEN +: XLEN] = wdata_i[k*XLEN +: XLEN];
            hit = 1'b1;
          end
        end
`endif
        busy_o[p] = pending[ra] && !hit;
      end
    end
  end

endmodule
